// File: rtl/gcd_controller_if.sv
// rtl/gcd_controller_if.sv - host/datapath handshake bundle for gcd_controller (iter_count present under GCD_ITER_COUNT_EN)
interface gcd_controller_if #(
    parameter int ITER_W = 16
);
    logic start;
    logic lt;
    logic gt;
    logic eq;
    logic ldA;
    logic ldB;
    logic sel1;
    logic sel2;
    logic sel_in;
    logic busy;
    logic done;
    logic err;
`ifdef GCD_ITER_COUNT_EN
    logic [ITER_W-1:0] iter_count;
`endif

    modport master (
        input  start, lt, gt, eq,
        output ldA, ldB, sel1, sel2, sel_in, busy, done, err
`ifdef GCD_ITER_COUNT_EN
        , output iter_count
`endif
    );

    modport slave (
        output start, lt, gt, eq,
        input  ldA, ldB, sel1, sel2, sel_in, busy, done, err
`ifdef GCD_ITER_COUNT_EN
        , input iter_count
`endif
    );
endinterface

// File: rtl/gcd_controller.sv
// rtl/gcd_controller.sv - sequencing FSM for the subtract-and-compare GCD datapath; GCD_ITER_COUNT_EN exposes iter_count
// MAX_ITER must be below 2**ITER_W; the counter saturates there and never wraps.
module gcd_controller #(
    parameter int ITER_W   = 16,
    parameter int MAX_ITER = 65535
) (
    input  logic              clk,
    input  logic              rst,
    gcd_controller_if.master  bus
);
    localparam logic [ITER_W-1:0] ITER_LIMIT = ITER_W'(MAX_ITER);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_CALC,
        S_DONE
    } state_t;

    state_t            state, state_next;
    logic [ITER_W-1:0] iter_cnt, iter_next;
    logic              err_q, err_next;

    logic ld_a, ld_b, sel_1, sel_2, sel_bus, busy_o, done_o, err_o;
    logic flags_onehot;

    // Exactly one of lt/gt/eq: odd parity rules out 0 and 2, the AND rules out 3.
    assign flags_onehot = (bus.lt ^ bus.gt ^ bus.eq) & ~(bus.lt & bus.gt & bus.eq);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            iter_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_next;
            iter_cnt <= iter_next;
            err_q    <= err_next;
        end
    end

    always_comb begin
        state_next = state;
        iter_next  = iter_cnt;
        err_next   = err_q;
        ld_a       = 1'b0;
        ld_b       = 1'b0;
        sel_1      = 1'b0;
        sel_2      = 1'b0;
        sel_bus    = 1'b0;
        busy_o     = 1'b0;
        done_o     = 1'b0;
        err_o      = 1'b0;
        case (state)
            S_IDLE: begin
                if (bus.start) state_next = S_LOAD_A;
            end
            S_LOAD_A: begin
                sel_bus    = 1'b1;
                ld_a       = 1'b1;
                busy_o     = 1'b1;
                iter_next  = '0;
                err_next   = 1'b0;
                state_next = S_LOAD_B;
            end
            S_LOAD_B: begin
                sel_bus    = 1'b1;
                ld_b       = 1'b1;
                busy_o     = 1'b1;
                state_next = S_CALC;
            end
            S_CALC: begin
                busy_o = 1'b1;
                if (!flags_onehot) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else if (bus.eq) begin
                    state_next = S_DONE;
                end else if (iter_cnt == ITER_LIMIT) begin
                    err_next   = 1'b1;
                    state_next = S_DONE;
                end else if (bus.gt) begin
                    sel_2     = 1'b1;
                    ld_a      = 1'b1;
                    iter_next = iter_cnt + 1'b1;
                end else begin
                    sel_1     = 1'b1;
                    ld_b      = 1'b1;
                    iter_next = iter_cnt + 1'b1;
                end
            end
            S_DONE: begin
                done_o = 1'b1;
                err_o  = err_q;
                if (bus.start) state_next = S_LOAD_A;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign bus.ldA    = ld_a;
    assign bus.ldB    = ld_b;
    assign bus.sel1   = sel_1;
    assign bus.sel2   = sel_2;
    assign bus.sel_in = sel_bus;
    assign bus.busy   = busy_o;
    assign bus.done   = done_o;
    assign bus.err    = err_o;
`ifdef GCD_ITER_COUNT_EN
    assign bus.iter_count = iter_cnt;
`endif
endmodule
